pkt_proc_enq_arbiter: RTL
=========================

// Module: pkt_proc_enq_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter sharing the packet processor enqueue port among NUM_REQ sources.
//  Admits a packet only when the processor FIFO has room for its full length, so no packet_drop occurs.
//  Drives enq_req/in_sop/wr_data_i/in_eop/pck_len_valid/pck_len_i; reads pck_proc_wr_lvl for space.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..8)
//  FIFO_DEPTH  16384  processor FIFO depth in 32-bit words
//  LVL_LAG     2      words of headroom covering wr_lvl update latency
// PORTS
//  pck_proc_int_mem_fsm_clk     in   1           single clock, all logic on posedge
//  pck_proc_int_mem_fsm_rstn    in   1           asynchronous reset, active-low
//  pck_proc_int_mem_fsm_sw_rstn in   1           synchronous soft reset, active-low, same effect as rstn
//  req_valid                    in   NUM_REQ     per-source word valid
//  req_sop / req_eop            in   NUM_REQ     per-source start/end of packet flags
//  req_data                     in   NUM_REQ*32  per-source data, flat, source i at [32i+:32]
//  req_len                      in   NUM_REQ*12  per-source packet length in words, valid with req_sop
//  req_ready                    out  NUM_REQ     per-source accept
//  pck_proc_wr_lvl              in   15          processor FIFO fill level in words
//  enq_req, in_sop, in_eop      out  1           enqueue strobe and packet delimiters
//  wr_data_i                    out  32          enqueue data
//  pck_len_valid                out  1           asserted with in_sop only
//  pck_len_i                    out  12          length of current packet
//  grant_id                     out  $clog2(NUM_REQ)  current or last granted source
//  err_len                      out  1           1-cycle pulse: word count != declared length
//  stat_pkt_cnt                 out  NUM_REQ*16  per-source packet counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (either): state IDLE; all outputs 0; rr pointer = 0 (source 0 has highest priority first).
//  Transfer rule: a word moves when req_valid[i] & req_ready[i].
//   req_ready is high only for the granted source in XFER.
//  FSM
//   IDLE: cand = req_valid & req_sop. If cand != 0, pick the first set bit at or after rr_ptr (wrapping).
//    Latch grant_id and len = req_len[grant]. Go to WAIT_SPACE.
//   WAIT_SPACE: free = FIFO_DEPTH - wr_lvl (16-bit, no underflow since wr_lvl <= FIFO_DEPTH).
//    If free >= len + LVL_LAG, go to XFER. Otherwise hold; there is no re-arbitration (large packets are not starved).
//   XFER: forward words from the granted source. On the handshake with req_eop, go to IDLE and set rr_ptr = grant+1 mod NUM_REQ.
//  Outputs are registered, 1 cycle after the handshake: enq_req=1, wr_data_i, in_sop, in_eop.
//   pck_len_valid = in_sop; pck_len_i = latched len.
//  Latency: sop in IDLE at cycle N -> first enq_req at N+3 (N+3 assumes space is available in WAIT_SPACE).
//   Throughput is 1 word/cycle within a packet; minimum gap between packets is 2 cycles.
//  Word counter: 12 bits, cleared at grant, +1 per word.
//   At eop, if count != len (including len == 0): pulse err_len 1 cycle after the eop word.
//   The packet still terminates on the source's eop.
//  A single-word packet (sop & eop) is legal: in_sop = in_eop = 1 in the same cycle.
//  Non-sop words from ungranted sources are not accepted; they stall at the source.
//  A reset in mid-packet aborts immediately: no in_eop is emitted.
//   The processor is reset by the same rstn, so this is consistent.
//  rr_ptr advances only on a completed packet.
// CONFIGURATION
//  PKT_ARB_STATS_EN defined: each source has a 16-bit saturating counter.
//   It increments on that source's eop handshake and is cleared by either reset.
//  PKT_ARB_STATS_EN undefined: stat_pkt_cnt is tied to 0 (the port is kept for interface stability).
// STRUCTURE
//  pkt_proc_arb_pkg: state_e {IDLE, WAIT_SPACE, XFER}, DATA_W=32, LEN_W=12, LVL_W=15, STAT_W=16.
//  Sub-module pkt_proc_rr_picker: combinational rotating-priority find-first (req, ptr -> onehot, idx, any).
// TESTING
//  1. Reset mid-XFER -> next cycle all outputs 0, req_ready 0, state IDLE.
//  2. Single source 0, len=4, 4 words (sop...eop), wr_lvl=0 -> enq_req high 4 cycles.
//     in_sop+pck_len_valid on word 1 with pck_len_i=4; in_eop on word 4; first enq 3 cycles after sop.
//  3. All 4 sources hold sop-words continuously, len=2 each -> grant order 0,1,2,3,0.
//     No interleaving of words between packets.
//  4. wr_lvl=16380, len=4 -> held in WAIT_SPACE with req_ready=0.
//     Drop wr_lvl to 16378 -> XFER starts; never a packet_drop from the processor.
//  5. len=3 with eop on word 2 -> 2 words forwarded; err_len pulses once, 1 cycle after the eop word.
//  6. Single-word packet len=1 -> in_sop=in_eop=pck_len_valid=1 in one cycle.
//     With PKT_ARB_STATS_EN: stat_pkt_cnt[0] goes 0 -> 1.

Source files
------------

// File: rtl/pkt_proc_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_proc_arb_pkg : shared widths and FSM encoding for the enqueue arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package pkt_proc_arb_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 12;
  localparam int LVL_W  = 15;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    XFER       = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pkt_proc_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_proc_rr_picker : rotating-priority find-first, search starts at ptr
// Revision 1.0
// ---------------------------------------------------------------------------
module pkt_proc_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pkt_proc_enq_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_proc_enq_arbiter : packet-atomic round-robin arbiter for the processor
// enqueue port; optional per-source packet counters under PKT_ARB_STATS_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module pkt_proc_enq_arbiter
  import pkt_proc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16384,
  parameter int LVL_LAG    = 2
) (
  input  logic                        pck_proc_int_mem_fsm_clk,
  input  logic                        pck_proc_int_mem_fsm_rstn,
  input  logic                        pck_proc_int_mem_fsm_sw_rstn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_sop,
  input  logic [NUM_REQ-1:0]          req_eop,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [LVL_W-1:0]            pck_proc_wr_lvl,
  output logic                        enq_req,
  output logic                        in_sop,
  output logic                        in_eop,
  output logic [DATA_W-1:0]           wr_data_i,
  output logic                        pck_len_valid,
  output logic [LEN_W-1:0]            pck_len_i,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        err_len,
  output logic [NUM_REQ*STAT_W-1:0]   stat_pkt_cnt
);

  localparam int          IDX_W   = $clog2(NUM_REQ);
  localparam logic [15:0] DEPTH_C = 16'(FIFO_DEPTH);
  localparam logic [15:0] LAG_C   = 16'(LVL_LAG);

  logic                clk;
  logic                rstn;
  logic                sw_rstn;
  assign clk     = pck_proc_int_mem_fsm_clk;
  assign rstn    = pck_proc_int_mem_fsm_rstn;
  assign sw_rstn = pck_proc_int_mem_fsm_sw_rstn;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [LEN_W-1:0]  len_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 enq_req_q, enq_req_d;
  logic                 in_sop_q, in_sop_d;
  logic                 in_eop_q, in_eop_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic                 pck_len_valid_q, pck_len_valid_d;
  logic [LEN_W-1:0]     pck_len_q, pck_len_d;
  logic                 err_len_q, err_len_d;

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  assign cand = req_valid & req_sop;

  pkt_proc_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (cand),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  logic [NUM_REQ-1:0] hs_vec;
  logic               xfer_hs;
  logic               sop_hs;
  logic               eop_hs;
  logic [LEN_W:0]     words_seen;
  logic [15:0]        free_words;
  logic [15:0]        need_words;
  logic [IDX_W-1:0]   rr_next;

  assign req_ready  = (state_q == XFER) ? grant_oh_q : '0;
  assign hs_vec     = req_valid & req_ready;
  assign xfer_hs    = |hs_vec;
  assign sop_hs     = |(hs_vec & req_sop);
  assign eop_hs     = |(hs_vec & req_eop);
  assign words_seen = {1'b0, cnt_q} + 1'b1;
  // wr_lvl never exceeds the depth, so this subtraction cannot wrap.
  assign free_words = DEPTH_C - {1'b0, pck_proc_wr_lvl};
  assign need_words = {{(16-LEN_W){1'b0}}, len_q} + LAG_C;
  assign rr_next    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    grant_oh_d      = grant_oh_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    enq_req_d       = xfer_hs;
    in_sop_d        = sop_hs;
    in_eop_d        = eop_hs;
    pck_len_valid_d = sop_hs;
    wr_data_d       = xfer_hs ? data_arr[grant_q] : wr_data_q;
    pck_len_d       = xfer_hs ? len_q : pck_len_q;
    err_len_d       = eop_hs && (words_seen != {1'b0, len_q});

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          len_d      = len_arr[pick_idx];
          cnt_d      = '0;
          state_d    = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        // Holding the grant here keeps long packets from being starved.
        if (free_words >= need_words) state_d = XFER;
      end
      XFER: begin
        if (xfer_hs) cnt_d = cnt_q + 1'b1;
        if (eop_hs) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!sw_rstn) begin
      state_d         = IDLE;
      rr_ptr_d        = '0;
      grant_d         = '0;
      grant_oh_d      = '0;
      len_d           = '0;
      cnt_d           = '0;
      enq_req_d       = 1'b0;
      in_sop_d        = 1'b0;
      in_eop_d        = 1'b0;
      pck_len_valid_d = 1'b0;
      wr_data_d       = '0;
      pck_len_d       = '0;
      err_len_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      grant_oh_q      <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      enq_req_q       <= 1'b0;
      in_sop_q        <= 1'b0;
      in_eop_q        <= 1'b0;
      pck_len_valid_q <= 1'b0;
      wr_data_q       <= '0;
      pck_len_q       <= '0;
      err_len_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      grant_oh_q      <= grant_oh_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      enq_req_q       <= enq_req_d;
      in_sop_q        <= in_sop_d;
      in_eop_q        <= in_eop_d;
      pck_len_valid_q <= pck_len_valid_d;
      wr_data_q       <= wr_data_d;
      pck_len_q       <= pck_len_d;
      err_len_q       <= err_len_d;
    end
  end

  assign enq_req       = enq_req_q;
  assign in_sop        = in_sop_q;
  assign in_eop        = in_eop_q;
  assign wr_data_i     = wr_data_q;
  assign pck_len_valid = pck_len_valid_q;
  assign pck_len_i     = pck_len_q;
  assign grant_id      = grant_q;
  assign err_len       = err_len_q;

`ifdef PKT_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [STAT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (eop_hs && (grant_q == IDX_W'(g)) && (pkt_cnt_q != '1))
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      if (!sw_rstn) pkt_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pkt_cnt_q <= '0;
      else       pkt_cnt_q <= pkt_cnt_d;
    end

    assign stat_pkt_cnt[g*STAT_W +: STAT_W] = pkt_cnt_q;
  end
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule
`default_nettype wire
